fib_seq: RTL and testbench

Parametrised Fibonacci sequence engine for the board-level display path. Two seeds are loaded from the slide switches, and the engine advances one term per single-step press or per divided tick in free-run mode. Carry-out of the term adder is detected. Each new term is presented to the LCD controller with a one-cycle update strobe. It replaces the fixed 16-bit generator and adds stepping, free-run rate, term index and overflow handling.

---
 rtl/fib_pkg.sv | 32 +++
 rtl/fib_seq_edge_sync.sv | 43 ++++
 rtl/fib_seq.sv | 184 ++++++++++++++++++
 tb/tb_fib_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the Fibonacci sequence engine:
//   - state_e   : engine state (IDLE, RUN, HALT)
//   - DEF_*     : default widths for the top-level parameters
//   - fib_sum() : one-bit-wider term adder used for carry-out detection
// -----------------------------------------------------------------------------
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_SEED_W = 4;
    localparam int DEF_IDX_W  = 8;

    // Operand width of fib_sum(). Callers zero-extend their WIDTH-bit terms
    // to this width, so WIDTH must stay below SUM_MAX_W.
    localparam int SUM_MAX_W  = 64;

    // Sum of two terms with one extra bit, so the carry-out is never lost.
    function automatic logic [SUM_MAX_W:0] fib_sum(
        input logic [SUM_MAX_W-1:0] a,
        input logic [SUM_MAX_W-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/fib_seq_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Brings an asynchronous, undebounced button into the clk domain and turns
// each rising edge into a single-cycle pulse.
//   clk   in  system clock
//   reset in  synchronous, active-high
//   d     in  raw button level (asynchronous to clk)
//   pulse out one-cycle pulse per rising edge of the synchronised level
// Two flops synchronise; a third holds the previous synchronised level for
// the edge compare. pulse is a decode of flop outputs only.
// -----------------------------------------------------------------------------
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/fib_seq.sv
// -----------------------------------------------------------------------------
// fib_seq
// Fibonacci sequence engine for the display path. Two seeds are loaded from
// the switches; the engine advances one term per step press (IDLE) or once
// every DIV clocks while run is held (RUN). Every load and every advance
// raises upd for one cycle alongside the new value/index/overflow.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high
//   switches  in   [SEED_W-1:0] seed, zero-extended on load
//   set_a     in   button: load a from switches
//   set_b     in   button: load b from switches
//   step      in   button: advance one term while not running
//   run       in   level: free-run, one advance per DIV clocks
//   value     out  [WIDTH-1:0] current term (register b)
//   index     out  [IDX_W-1:0] advances since last load/reset (wraps)
//   overflow  out  sticky carry-out flag, cleared by any load
//   upd       out  one-cycle strobe with each new output value
//   dbg_state out  [1:0] engine state (0=IDLE, 1=RUN, 2=HALT)
//
// Build option FIB_WRAP_EN:
//   undefined : an advance with carry-out sets overflow and halts without
//               committing; only a load (or reset) leaves HALT.
//   defined   : the carry-out advance commits modulo 2^WIDTH, overflow is
//               set, and the sequence keeps going. HALT is never entered.
//
// Priority within a cycle: reset > load > advance.
// WIDTH must be below fib_pkg::SUM_MAX_W (64).
// -----------------------------------------------------------------------------
module fib_seq
    import fib_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SEED_W = DEF_SEED_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int DIV    = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEED_W-1:0] switches,
    input  logic              set_a,
    input  logic              set_b,
    input  logic              step,
    input  logic              run,
    output logic [WIDTH-1:0]  value,
    output logic [IDX_W-1:0]  index,
    output logic              overflow,
    output logic              upd,
    output logic [1:0]        dbg_state
);

    localparam int TICK_W   = $clog2(DIV);
    localparam int PAD_W    = SUM_MAX_W - WIDTH;
    localparam int SEED_PAD = WIDTH - SEED_W;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);

    // Button events, one pulse per press.
    logic load_a, load_b, step_p;

    edge_sync u_sync_set_a (.clk(clk), .reset(reset), .d(set_a), .pulse(load_a));
    edge_sync u_sync_set_b (.clk(clk), .reset(reset), .d(set_b), .pulse(load_b));
    edge_sync u_sync_step  (.clk(clk), .reset(reset), .d(step),  .pulse(step_p));

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ovf_q, ovf_d;
    logic               upd_q, upd_d;
    logic [TICK_W-1:0]  tick_q, tick_d;

    logic [SUM_MAX_W:0] sum_full;
    logic [WIDTH-1:0]   sum_lo;
    logic               carry;
    logic [WIDTH-1:0]   seed;
    logic               tick_fire;
    logic               adv;

    always_comb begin
        sum_full = fib_sum({{PAD_W{1'b0}}, a_q}, {{PAD_W{1'b0}}, b_q});
        sum_lo   = sum_full[WIDTH-1:0];
        // Operands are zero-extended, so every bit above WIDTH-1 can only be
        // set by the carry out of the WIDTH-bit addition.
        carry    = |sum_full[SUM_MAX_W:WIDTH];
        seed     = {{SEED_PAD{1'b0}}, switches};
    end

    assign tick_fire = (state_q == RUN) && (tick_q == TICK_LAST);

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        upd_d   = 1'b0;
        state_d = state_q;
        adv     = 1'b0;

        case (state_q)
            IDLE: begin
                adv = step_p;
                if (run) state_d = RUN;
            end
            RUN: begin
                // Step presses are deliberately ignored while free-running.
                adv = tick_fire;
                if (!run) state_d = IDLE;
            end
            default: begin
`ifdef FIB_WRAP_EN
                state_d = IDLE;
`else
                state_d = HALT;
`endif
            end
        endcase

        if (load_a || load_b) begin
            // A load discards any advance requested in the same cycle.
            if (load_a) a_d = seed;
            if (load_b) b_d = seed;
            idx_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
            upd_d   = 1'b1;
        end else if (adv) begin
            upd_d = 1'b1;
`ifdef FIB_WRAP_EN
            a_d   = b_q;
            b_d   = sum_lo;
            idx_d = idx_q + IDX_W'(1);
            if (carry) ovf_d = 1'b1;
`else
            if (carry) begin
                // Keep the last valid term on display and stop.
                ovf_d   = 1'b1;
                state_d = HALT;
            end else begin
                a_d   = b_q;
                b_d   = sum_lo;
                idx_d = idx_q + IDX_W'(1);
            end
`endif
        end
    end

    // Divider only runs while staying in RUN, so the first tick lands DIV
    // cycles after RUN is entered and it reads zero everywhere else.
    always_comb begin
        if ((state_q == RUN) && (state_d == RUN)) begin
            tick_d = tick_fire ? '0 : tick_q + TICK_W'(1);
        end else begin
            tick_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= WIDTH'(1);
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            upd_q   <= 1'b0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            upd_q   <= upd_d;
            tick_q  <= tick_d;
        end
    end

    assign value     = b_q;
    assign index     = idx_q;
    assign overflow  = ovf_q;
    assign upd       = upd_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fib_seq.sv
// -----------------------------------------------------------------------------
// tb_fib_seq
// Directed bench for fib_seq (WIDTH=16, SEED_W=4, IDX_W=8, DIV=4).
// Each expected update is queued as {overflow, index, value} before the
// stimulus that causes it; a monitor pops and compares on every upd.
// Honors FIB_WRAP_EN for the overflow expectations.
// -----------------------------------------------------------------------------
module tb_fib_seq;

    localparam int W = 25;  // {overflow, index[7:0], value[15:0]}

    logic        clk;
    logic        reset;
    logic [3:0]  switches;
    logic        set_a, set_b, step, run;
    logic [15:0] value;
    logic [7:0]  index;
    logic        overflow;
    logic        upd;
    logic [1:0]  dbg_state;

    fib_seq #(.WIDTH(16), .SEED_W(4), .IDX_W(8), .DIV(4)) dut (
        .clk(clk), .reset(reset), .switches(switches),
        .set_a(set_a), .set_b(set_b), .step(step), .run(run),
        .value(value), .index(index), .overflow(overflow),
        .upd(upd), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           upd_cyc_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    // Value after k+1 steps from reset (a=0, b=1).
    int fib_tab[23] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610,
                        987, 1597, 2584, 4181, 6765, 10946, 17711, 28657, 46368};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic push_exp(input logic ovf, input int idx, input int val);
        exp_q.push_back({ovf, 8'(idx), 16'(val)});
    endtask

    always @(negedge clk) begin
        if (upd === 1'b1) begin
            upd_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_upd: got value=%0d index=%0d overflow=%0b, expected no update",
                         value, index, overflow);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("upd_term", {7'd0, overflow, index, value}, {7'd0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    int press_cyc;

    task automatic press(input logic pa, input logic pb, input logic ps);
        @(negedge clk);
        set_a = pa; set_b = pb; step = ps;
        press_cyc = cyc;
        repeat (4) @(negedge clk);
        set_a = 1'b0; set_b = 1'b0; step = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        reset = 1'b1; switches = '0;
        set_a = 1'b0; set_b = 1'b0; step = 1'b0; run = 1'b0;

        // Reset values
        do_reset();
        check("rst_value", 32'(value), 32'd1);
        check("rst_index", 32'(index), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_upd", 32'(upd), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // Ten single steps, plus button-to-output latency on the first
        upd_cyc_q.delete();
        for (int k = 0; k < 10; k++) begin
            push_exp(1'b0, k + 1, fib_tab[k]);
            press(1'b0, 1'b0, 1'b1);
            if (k == 0) begin
                check("latency_seen", 32'(upd_cyc_q.size()), 32'd1);
                if (upd_cyc_q.size() > 0)
                    check("latency_n_plus_3", 32'(upd_cyc_q[0] - press_cyc), 32'd3);
            end
            wait_drain("step_drain");
        end
        check("step_index10", 32'(index), 32'd10);
        check("step_upd_count", 32'(upd_cyc_q.size()), 32'd10);

        // Seed loads then three steps: 3,4 -> 7, 11, 18
        switches = 4'd3;
        push_exp(1'b0, 0, 89);
        press(1'b1, 1'b0, 1'b0);
        wait_drain("load_a_drain");
        switches = 4'd4;
        push_exp(1'b0, 0, 4);
        press(1'b0, 1'b1, 1'b0);
        wait_drain("load_b_drain");
        push_exp(1'b0, 1, 7);
        push_exp(1'b0, 2, 11);
        push_exp(1'b0, 3, 18);
        for (int k = 0; k < 3; k++) press(1'b0, 1'b0, 1'b1);
        wait_drain("seed_steps_drain");

        // Free-run: a=11, b=18 -> 29, 47, 76, 123, DIV=4 cycles apart
        upd_cyc_q.delete();
        push_exp(1'b0, 4, 29);
        push_exp(1'b0, 5, 47);
        push_exp(1'b0, 6, 76);
        push_exp(1'b0, 7, 123);
        @(negedge clk);
        run = 1'b1;
        begin
            int run_cyc;
            run_cyc = cyc;
            @(negedge clk);
            check("run_state", 32'(dbg_state), 32'd1);
            repeat (17) @(negedge clk);
            run = 1'b0;
            repeat (10) @(negedge clk);
            check("run_adv_count", 32'(upd_cyc_q.size()), 32'd4);
            if (upd_cyc_q.size() == 4) begin
                check("run_first_tick", 32'(upd_cyc_q[0] - (run_cyc + 1)), 32'd4);
                for (int k = 1; k < 4; k++)
                    check("run_spacing", 32'(upd_cyc_q[k] - upd_cyc_q[k-1]), 32'd4);
            end
        end
        wait_drain("run_drain");
        check("run_stop_value", 32'(value), 32'd123);
        check("run_stop_state", 32'(dbg_state), 32'd0);

        // Overflow from reset: 23 clean steps, then the carry-out step
        do_reset();
        for (int k = 0; k < 23; k++) begin
            push_exp(1'b0, k + 1, fib_tab[k]);
            press(1'b0, 1'b0, 1'b1);
        end
        wait_drain("ovf_pre_drain");
        check("ovf_pre_value", 32'(value), 32'd46368);
`ifdef FIB_WRAP_EN
        push_exp(1'b1, 24, 9489);
        press(1'b0, 1'b0, 1'b1);
        wait_drain("wrap24_drain");
        check("wrap24_state", 32'(dbg_state), 32'd0);
        push_exp(1'b1, 25, 55857);
        press(1'b0, 1'b0, 1'b1);
        wait_drain("wrap25_drain");
`else
        push_exp(1'b1, 23, 46368);
        press(1'b0, 1'b0, 1'b1);
        wait_drain("ovf24_drain");
        check("ovf24_state_halt", 32'(dbg_state), 32'd2);
        press(1'b0, 1'b0, 1'b1);  // ignored while halted
        wait_drain("halt_step_drain");
        check("halt_value", 32'(value), 32'd46368);
        check("halt_index", 32'(index), 32'd23);
        check("halt_overflow", 32'(overflow), 32'd1);
`endif
        switches = 4'd5;
        push_exp(1'b0, 0, 5);
        press(1'b0, 1'b1, 1'b0);
        wait_drain("ovf_clear_drain");
        check("ovf_clear_flag", 32'(overflow), 32'd0);
        check("ovf_clear_state", 32'(dbg_state), 32'd0);

        // set_a and step in the same cycle: load wins, step dropped
        do_reset();
        switches = 4'd2;
        push_exp(1'b0, 0, 1);
        press(1'b1, 1'b0, 1'b1);
        wait_drain("coincide_drain");
        push_exp(1'b0, 1, 3);   // a=2, b=1 -> 3 proves a was loaded
        press(1'b0, 1'b0, 1'b1);
        wait_drain("coincide_step_drain");

        // Reset asserted during RUN: a=1, b=3 -> one advance to 4, then reset
        push_exp(1'b0, 2, 4);
        @(negedge clk);
        run = 1'b1;
        wait_drain("rst_run_drain");
        check("rst_run_state", 32'(dbg_state), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_rst_value", 32'(value), 32'd1);
        check("midrun_rst_index", 32'(index), 32'd0);
        check("midrun_rst_overflow", 32'(overflow), 32'd0);
        check("midrun_rst_upd", 32'(upd), 32'd0);
        check("midrun_rst_state", 32'(dbg_state), 32'd0);
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
